// File: rtl/pipelined_cla_addsub_pkg.sv
// pipelined_cla_addsub_pkg: op encodings and flag bit positions shared by the add/sub pipeline
package pipelined_cla_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLAG_W = 4;

    typedef enum int unsigned {
        FLAG_CARRY = 0,
        FLAG_OVF   = 1,
        FLAG_NEG   = 2,
        FLAG_ZERO  = 3
    } flag_e;

endpackage

// File: rtl/pipelined_cla_addsub_segment.sv
// cla_segment: combinational W-bit carry-lookahead slice
//   a, b   : slice operands (b already inverted by the caller for subtract)
//   cin    : carry into the slice LSB
//   sum    : slice sum
//   cout   : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (needed for signed overflow)
module cla_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         run;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened lookahead sum of products
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, not a ripple chain.
    always_comb begin
        c = '0;
        run = 1'b0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i];
            run = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run & g[j]);
                run = run & p[j];
            end
            c[i+1] = c[i+1] | (run & cin);
        end
    end

    assign sum   = p ^ c[W-1:0];
    assign cout  = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: N-bit add/subtract, one SEG-bit CLA slice per pipeline stage
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (a, b, is_subtract, saturate)
//   out_valid / out_ready : output handshake (result, carry, overflow, negative, zero)
module pipelined_cla_addsub
    import pipelined_cla_addsub_pkg::*;
#(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_subtract,
    input  logic         saturate,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         overflow,
    output logic         negative,
    output logic         zero
);

    localparam int STAGES = N / SEG;
    localparam int L = STAGES - 1;
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    logic advance;

    // Stage k inputs: stage 0 reads the ports, later stages read the
    // previous stage's registers. Operands are shifted right one slice per
    // stage so the bits a stage needs are always at [SEG-1:0].
    logic [N-1:0] a_i [STAGES];
    logic [N-1:0] b_i [STAGES];
    logic [N-1:0] s_i [STAGES];
    logic         c_i [STAGES];
    logic         sub_i [STAGES];
    logic         sat_i [STAGES];
    logic         v_i [STAGES];

    logic [N-1:0] a_q [STAGES-1];
    logic [N-1:0] b_q [STAGES-1];
    logic [N-1:0] s_q [STAGES-1];
    logic         c_q [STAGES-1];
    logic         sub_q [STAGES-1];
    logic         sat_q [STAGES-1];
    logic         v_q [STAGES-1];

    logic [SEG-1:0] sum_k [STAGES];
    logic           cout_k [STAGES];
    logic           cmsb_k [STAGES];

    logic [N-1:0]      raw;
    logic [N-1:0]      res_d;
    logic              ovf_d;
    logic              neg_d;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] flags_q;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign a_i[k]   = a;
            assign b_i[k]   = b;
            assign s_i[k]   = '0;
            assign c_i[k]   = (is_subtract == OP_SUB);
            assign sub_i[k] = is_subtract;
            assign sat_i[k] = saturate;
            assign v_i[k]   = in_valid;
        end else begin : g_src
            assign a_i[k]   = a_q[k-1];
            assign b_i[k]   = b_q[k-1];
            assign s_i[k]   = s_q[k-1];
            assign c_i[k]   = c_q[k-1];
            assign sub_i[k] = sub_q[k-1];
            assign sat_i[k] = sat_q[k-1];
            assign v_i[k]   = v_q[k-1];
        end
        cla_segment #(.W(SEG)) u_seg (
            .a     (a_i[k][SEG-1:0]),
            .b     ((sub_i[k] == OP_ADD) ? b_i[k][SEG-1:0] : ~b_i[k][SEG-1:0]),
            .cin   (c_i[k]),
            .sum   (sum_k[k]),
            .cout  (cout_k[k]),
            .c_msb (cmsb_k[k])
        );
    end

    // Final slice: assemble the raw sum, derive flags from the raw add and
    // clamp only the result on signed overflow.
    always_comb begin
        raw = s_i[L] | (N'(sum_k[L]) << (L * SEG));
        ovf_d = cout_k[L] ^ cmsb_k[L];
        neg_d = ovf_d ^ raw[N-1];
        res_d = (sat_i[L] && ovf_d) ? (neg_d ? SAT_MIN : SAT_MAX) : raw;
        flags_d = '0;
        flags_d[FLAG_CARRY] = cout_k[L];
        flags_d[FLAG_OVF] = ovf_d;
        flags_d[FLAG_NEG] = neg_d;
        flags_d[FLAG_ZERO] = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                sat_q[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                v_q[k]   <= v_i[k];
                a_q[k]   <= a_i[k] >> SEG;
                b_q[k]   <= b_i[k] >> SEG;
                s_q[k]   <= s_i[k] | (N'(sum_k[k]) << (k * SEG));
                c_q[k]   <= cout_k[k];
                sub_q[k] <= sub_i[k];
                sat_q[k] <= sat_i[k];
            end
            out_valid <= v_i[L];
            result    <= res_d;
            flags_q   <= flags_d;
        end
    end

    assign carry    = flags_q[FLAG_CARRY];
    assign overflow = flags_q[FLAG_OVF];
    assign negative = flags_q[FLAG_NEG];
    assign zero     = flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: randomized and directed checks of the add/sub pipeline against an arithmetic model
module tb_pipelined_cla_addsub;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
    } res_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        is_subtract;
    logic        saturate;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        negative;
    logic        zero;

    int tests = 0;
    int fails = 0;

    pipelined_cla_addsub #(.N(16), .SEG(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .is_subtract (is_subtract),
        .saturate    (saturate),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry       (carry),
        .overflow    (overflow),
        .negative    (negative),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t cur();
        return {result, carry, overflow, negative, zero};
    endfunction

    // Exact signed arithmetic decides overflow and sign; the 17-bit unsigned
    // sum of a + (b or ~b+1) gives the carry and the wrapped result.
    function automatic res_t model(logic [15:0] x, logic [15:0] y, bit sub, bit sat);
        logic [16:0] u;
        int e;
        res_t o;
        u = sub ? ({1'b0, x} + {1'b0, ~y} + 17'd1) : ({1'b0, x} + {1'b0, y});
        e = sub ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
        o.v = (e > 32767) || (e < -32768);
        o.n = (e < 0);
        o.c = u[16];
        o.r = (sat && o.v) ? (o.n ? 16'h8000 : 16'h7FFF) : u[15:0];
        o.z = (o.r == 16'h0000);
        return o;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Drive one cycle, observe handshake and outputs just before the edge,
    // then return 1 time unit after the edge.
    task automatic step(input bit iv, input logic [15:0] ia, input logic [15:0] ib,
                        input bit isub, input bit isat, input bit ordy,
                        output bit ti, output bit to, output res_t snap,
                        output bit st, output bit ir);
        in_valid = iv;
        a = ia;
        b = ib;
        is_subtract = isub;
        saturate = isat;
        out_ready = ordy;
        #1;
        ir = in_ready;
        ti = iv && in_ready;
        to = out_valid && ordy;
        st = out_valid && !ordy;
        snap = cur();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input bit sub, input bit sat,
                         output res_t o, output int lat);
        bit ti, to, st, ir;
        res_t sn;
        step(1'b1, x, y, sub, sat, 1'b1, ti, to, sn, st, ir);
        lat = 1;
        while (!out_valid && lat < 12) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, ti, to, sn, st, ir);
            lat++;
        end
        o = cur();
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, ti, to, sn, st, ir);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        is_subtract = 1'b0;
        saturate = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++;
        if (cur() !== res_t'(0)) begin fails++; $display("FAIL reset_outputs: got %h want 0", cur()); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        res_t o;
        int lat;
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, o, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL add_latency: got %0d want 4", lat); end
        tests++;
        if (o !== {16'h2233, 4'b0000}) begin fails++; $display("FAIL add_1234_0fff: got %h want %h", o, {16'h2233, 4'b0000}); end
    endtask

    task automatic test_subtract();
        res_t o;
        int lat;
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, o, lat);
        tests++;
        if (o !== {16'hFFFE, 4'b0010}) begin fails++; $display("FAIL sub_5_7: got %h want %h", o, {16'hFFFE, 4'b0010}); end
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, o, lat);
        tests++;
        if (o !== {16'h0000, 4'b1001}) begin fails++; $display("FAIL sub_8000_8000: got %h want %h", o, {16'h0000, 4'b1001}); end
    endtask

    task automatic test_overflow();
        res_t o;
        int lat;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, o, lat);
        tests++;
        if (o !== {16'h8000, 4'b0100}) begin fails++; $display("FAIL ovf_nosat: got %h want %h", o, {16'h8000, 4'b0100}); end
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, o, lat);
        tests++;
        if (o !== {16'h7FFF, 4'b0100}) begin fails++; $display("FAIL ovf_sat_pos: got %h want %h", o, {16'h7FFF, 4'b0100}); end
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, o, lat);
        tests++;
        if (o !== {16'h8000, 4'b1110}) begin fails++; $display("FAIL ovf_sat_neg: got %h want %h", o, {16'h8000, 4'b1110}); end
    endtask

    task automatic test_ripple();
        res_t o;
        int lat;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, o, lat);
        tests++;
        if (o !== {16'h0000, 4'b1001}) begin fails++; $display("FAIL ripple_ffff_1: got %h want %h", o, {16'h0000, 4'b1001}); end
    endtask

    task automatic test_back_to_back();
        res_t exp_q[$];
        logic [15:0] xa[8];
        logic [15:0] xb[8];
        bit xs[8];
        bit xt[8];
        int sent, got, stalls;
        bit ti, to, st, ir;
        res_t sn;
        sent = 0;
        got = 0;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            xa[i] = pick();
            xb[i] = pick();
            xs[i] = 1'($urandom);
            xt[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            step(sent < 8, xa[sent % 8], xb[sent % 8], xs[sent % 8], xt[sent % 8],
                 !(cyc >= 3 && cyc <= 6), ti, to, sn, st, ir);
            if (to) begin
                tests++;
                if (exp_q.size() == 0 || sn !== exp_q[0]) begin
                    fails++;
                    $display("FAIL b2b_result%0d: got %h want %h", got, sn, exp_q.size() ? exp_q[0] : res_t'(0));
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (ti) begin
                exp_q.push_back(model(xa[sent], xb[sent], xs[sent], xt[sent]));
                sent++;
            end
            if (st) begin
                stalls++;
                tests++;
                if (ir !== 1'b0) begin fails++; $display("FAIL b2b_stall_in_ready: got %b want 0", ir); end
                tests++;
                if (out_valid !== 1'b1 || cur() !== sn) begin fails++; $display("FAIL b2b_stall_hold: got %h want %h", cur(), sn); end
            end
        end
        tests++;
        if (got !== 8 || sent !== 8) begin fails++; $display("FAIL b2b_count: got %0d out %0d in want 8 8", got, sent); end
        tests++;
        if (stalls !== 3) begin fails++; $display("FAIL b2b_stall_cycles: got %0d want 3", stalls); end
    endtask

    task automatic test_random();
        res_t exp_q[$];
        int ops, cyc;
        logic [15:0] ra, rb;
        bit rs, rt, rv, rr;
        bit ti, to, st, ir;
        res_t sn;
        ops = 0;
        cyc = 0;
        while (ops < 10000 && cyc < 40000) begin
            ra = pick();
            rb = pick();
            rs = 1'($urandom);
            rt = 1'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            step(rv, ra, rb, rs, rt, rr, ti, to, sn, st, ir);
            cyc++;
            if (to) begin
                tests++;
                if (exp_q.size() == 0 || sn !== exp_q[0]) begin
                    fails++;
                    $display("FAIL rand_result: got %h want %h", sn, exp_q.size() ? exp_q[0] : res_t'(0));
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (ti) begin
                exp_q.push_back(model(ra, rb, rs, rt));
                ops++;
            end
            if (st) begin
                tests++;
                if (ir !== 1'b0 || out_valid !== 1'b1 || cur() !== sn) begin
                    fails++;
                    $display("FAIL rand_stall_hold: got %h ready %b want %h ready 0", cur(), ir, sn);
                end
            end
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, ti, to, sn, st, ir);
            if (to) begin
                tests++;
                if (sn !== exp_q[0]) begin fails++; $display("FAIL rand_drain: got %h want %h", sn, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        tests++;
        if (ops !== 10000 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL rand_complete: got %0d ops %0d pending want 10000 0", ops, exp_q.size());
        end
    endtask

    task automatic test_reset_in_flight();
        bit ti, to, st, ir;
        res_t sn, o;
        int lat;
        logic [15:0] x, y;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, ti, to, sn, st, ir);
        end
        rst = 1'b1;
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, ti, to, sn, st, ir);
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_flight_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, ti, to, sn, st, ir);
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_flight_stale%0d: got %b want 0", i, out_valid); end
        end
        x = pick();
        y = pick();
        do_op(x, y, 1'b1, 1'b1, o, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL rst_flight_latency: got %0d want 4", lat); end
        tests++;
        if (o !== model(x, y, 1'b1, 1'b1)) begin fails++; $display("FAIL rst_flight_first: got %h want %h", o, model(x, y, 1'b1, 1'b1)); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_overflow();
        test_ripple();
        test_back_to_back();
        test_random();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
